flit_latency_sink: RTL

//  Terminal consumer directly downstream of the flit traffic generator / NoC output port. Accepts 64-bit flits,

---
 rtl/flit_latency_sink_if.sv | 11 +
 rtl/flit_latency_sink.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/flit_latency_sink_if.sv
// Flit delivery channel from the traffic generator / NoC output port to the latency sink.
// Handshake: a flit transfers on a rising clk edge where flit_valid & flit_ready are both 1;
// flit_in is only meaningful while flit_valid is 1, and the sink never deasserts ready once up.
interface flit_latency_sink_if;
  logic [63:0] flit_in;
  logic        flit_valid;
  logic        flit_ready;

  modport master (output flit_in, output flit_valid, input flit_ready);
  modport slave  (input flit_in, input flit_valid, output flit_ready);
endinterface

// File: rtl/flit_latency_sink.sv
// Terminal flit consumer: checks head/body/tail framing and destination, timestamps packets
// against a local free-running counter and keeps per-packet latency statistics.
module flit_latency_sink #(
  parameter logic [7:0] MY_ADDR = 8'h01,
  parameter int         PKT_LEN = 11,
  parameter int         TS_W    = 22,
  parameter int         SUM_W   = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  flit_latency_sink_if.slave   flit_if,
  input  logic                 clear,
  output logic                 pkt_done,
  output logic [TS_W-1:0]      last_latency,
  output logic [TS_W-1:0]      min_latency,
  output logic [TS_W-1:0]      max_latency,
  output logic [SUM_W-1:0]     latency_sum,
  output logic [31:0]          pkt_count,
  output logic [31:0]          flit_count,
  output logic [15:0]          err_count,
  output logic [15:0]          misroute_cnt,
  output logic                 dbg_state
);

  localparam int IDX_W = $clog2(PKT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] flit_idx;
  logic [TS_W-1:0]  cycle_cnt;
  logic [TS_W-1:0]  pend_lat;

  logic [1:0]       ftype;
  logic [7:0]       fdest;
  logic [21:0]      fts;
  logic             accept;
  logic             is_head;
  logic             is_body;
  logic             is_tail;
  logic             is_ill;
  logic             err_ev;
  logic             mis_ev;
  logic             done_ev;
  logic [TS_W-1:0]  head_lat;
  logic [SUM_W:0]   sum_ext;
  logic [SUM_W-1:0] sum_next;

  // Classify the flit on the channel and decide which counters this transfer touches.
  always_comb begin
    ftype    = flit_if.flit_in[63:62];
    fdest    = flit_if.flit_in[61:54];
    fts      = flit_if.flit_in[53:32];
    accept   = flit_if.flit_valid & flit_if.flit_ready;
    is_head  = (ftype == 2'b01);
    is_body  = (ftype == 2'b00);
    is_tail  = (ftype == 2'b10);
    is_ill   = (ftype == 2'b11);
    head_lat = cycle_cnt - TS_W'(fts);
    err_ev   = 1'b0;
    mis_ev   = 1'b0;
    done_ev  = 1'b0;
    if (accept) begin
      mis_ev = is_head && (fdest != MY_ADDR);
      if (state == IDLE) begin
        err_ev = !is_head;
      end else begin
        err_ev  = is_head || is_ill ||
                  (is_body && (flit_idx == LAST_IDX)) ||
                  (is_tail && (flit_idx != LAST_IDX));
        done_ev = is_tail && (flit_idx == LAST_IDX);
      end
    end
    sum_ext  = {1'b0, latency_sum} + (SUM_W + 1)'(pend_lat);
    sum_next = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
  end

  assign dbg_state = (state == IN_PKT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= IDLE;
      flit_idx           <= '0;
      cycle_cnt          <= '0;
      pend_lat           <= '0;
      flit_if.flit_ready <= 1'b0;
      pkt_done           <= 1'b0;
      last_latency       <= '0;
      min_latency        <= '1;
      max_latency        <= '0;
      latency_sum        <= '0;
      pkt_count          <= '0;
      flit_count         <= '0;
      err_count          <= '0;
      misroute_cnt       <= '0;
    end else begin
      cycle_cnt          <= cycle_cnt + 1'b1;
      flit_if.flit_ready <= 1'b1;
      pkt_done           <= done_ev;

      if (accept) begin
        case (state)
          IDLE: begin
            if (is_head) begin
              state    <= IN_PKT;
              flit_idx <= IDX_W'(1);
              pend_lat <= head_lat;
            end
          end
          IN_PKT: begin
            if (is_head) begin
              // A new head abandons the open packet and starts tracking the new one.
              flit_idx <= IDX_W'(1);
              pend_lat <= head_lat;
            end else if (is_body) begin
              if (flit_idx == LAST_IDX) state <= IDLE;
              else flit_idx <= flit_idx + IDX_W'(1);
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Clear beats any same-cycle statistic update; pkt_done above is unaffected.
      if (clear) begin
        last_latency <= '0;
        min_latency  <= '1;
        max_latency  <= '0;
        latency_sum  <= '0;
        pkt_count    <= '0;
        flit_count   <= '0;
        err_count    <= '0;
        misroute_cnt <= '0;
      end else begin
        if (accept) flit_count <= flit_count + 32'd1;
        if (err_ev && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
        if (mis_ev && (misroute_cnt != 16'hFFFF)) misroute_cnt <= misroute_cnt + 16'd1;
        if (done_ev) begin
          last_latency <= pend_lat;
          min_latency  <= (pend_lat < min_latency) ? pend_lat : min_latency;
          max_latency  <= (pend_lat > max_latency) ? pend_lat : max_latency;
          latency_sum  <= sum_next;
          pkt_count    <= pkt_count + 32'd1;
        end
      end
    end
  end

endmodule
